// File: rtl/avalon_pkt_enforcer_pkg.sv
// Shared definitions for the Avalon-ST packet enforcer: sizing helper,
// the framing state enum and the empty-to-keep-mask conversion.
package general_pack;

    // Upper bound on symbols per beat supported by empty_to_mask; callers
    // take the low DATA_WIDTH_IN_BYTES bits of the returned mask.
    localparam int MAX_SYMBOLS = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_MSG = 2'd1,
        DROP   = 2'd2
    } enforcer_state_t;

    // Bits needed to hold values 0..value-1 (minimum 1).
    function automatic int log2up_func(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Symbol keep mask: bit i is set when symbol i carries valid data,
    // i.e. symbols below 'empty' are the unused ones on an EOP beat.
    function automatic logic [MAX_SYMBOLS-1:0] empty_to_mask(input int unsigned empty);
        logic [MAX_SYMBOLS-1:0] mask;
        for (int i = 0; i < MAX_SYMBOLS; i++) begin
            mask[i] = (unsigned'(i) >= empty);
        end
        return mask;
    endfunction

endpackage

// File: rtl/avalon_pkt_enforcer_if.sv
// Avalon-ST streaming bundle (valid/rdy handshake plus sop/eop/data/empty).
interface avalon_st_if
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EMPTY_W = log2up_func(DATA_WIDTH_IN_BYTES);

    logic                             valid;
    logic                             rdy;
    logic                             sop;
    logic                             eop;
    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic [EMPTY_W-1:0]               empty;

    modport master (
        output valid, sop, eop, data, empty,
        input  rdy
    );

    modport slave (
        input  valid, sop, eop, data, empty,
        output rdy
    );
endinterface

// File: rtl/avalon_pkt_enforcer_out_reg.sv
// One-deep ready/valid register stage driving an Avalon-ST master port.
// Payload is only written on a load, so a drain without a new beat leaves
// the last data visible with valid low.
module avalon_st_out_reg
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    input  logic                                       in_sop,
    input  logic                                       in_eop,
    input  logic [8*DATA_WIDTH_IN_BYTES-1:0]           in_data,
    input  logic [log2up_func(DATA_WIDTH_IN_BYTES)-1:0] in_empty,
    output logic                                       in_rdy,
    avalon_st_if.master                                out
);
    localparam int EMPTY_W = log2up_func(DATA_WIDTH_IN_BYTES);

    logic                             valid_reg;
    logic                             sop_reg;
    logic                             eop_reg;
    logic [8*DATA_WIDTH_IN_BYTES-1:0] data_reg;
    logic [EMPTY_W-1:0]               empty_reg;

    // Space is available when empty or when the current beat leaves this cycle.
    assign in_rdy = !valid_reg || out.rdy;

    // Load on accept (covers simultaneous drain), otherwise clear valid on drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            sop_reg   <= 1'b0;
            eop_reg   <= 1'b0;
            data_reg  <= '0;
            empty_reg <= '0;
        end else if (in_valid && in_rdy) begin
            valid_reg <= 1'b1;
            sop_reg   <= in_sop;
            eop_reg   <= in_eop;
            data_reg  <= in_data;
            empty_reg <= in_empty;
        end else if (out.rdy) begin
            valid_reg <= 1'b0;
        end
    end

    assign out.valid = valid_reg;
    assign out.sop   = sop_reg;
    assign out.eop   = eop_reg;
    assign out.data  = data_reg;
    assign out.empty = empty_reg;

endmodule

// File: rtl/avalon_pkt_enforcer.sv
// Avalon-ST packet-framing enforcer: drops beats outside a message, strips
// stray SOPs, truncates over-long messages, zeroes empty symbols on EOP.
// Optional statistics counters: define AVALON_ENFORCER_STATS_EN.
module avalon_pkt_enforcer
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_MSG_BEATS       = 64,
    parameter int CNT_WIDTH           = 16
) (
    input  logic              clk,
    input  logic              rst,
    avalon_st_if.slave        untrusted_msg,
    avalon_st_if.master       enforced_msg,
    output logic              missing_sop_indi,
    output logic              unexpected_sop_indi,
    output logic              truncated_indi
`ifdef AVALON_ENFORCER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] missing_sop_cnt,
    output logic [CNT_WIDTH-1:0] unexpected_sop_cnt,
    output logic [CNT_WIDTH-1:0] truncated_cnt
`endif
);
    localparam int SYMBOLS = DATA_WIDTH_IN_BYTES;
    localparam int DATA_W  = 8 * SYMBOLS;
    localparam int EMPTY_W = log2up_func(SYMBOLS);
    localparam int BEAT_W  = log2up_func(MAX_MSG_BEATS + 1);
    localparam logic [BEAT_W-1:0] MAX_BEATS = BEAT_W'(MAX_MSG_BEATS);
    localparam logic [BEAT_W-1:0] ONE_BEAT  = BEAT_W'(1);

    enforcer_state_t     state_reg, state_next;
    logic [BEAT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [BEAT_W-1:0]   beat_inc;

    logic                accept;
    logic                out_rdy;
    logic [EMPTY_W-1:0]  empty_clamped;
    logic [MAX_SYMBOLS-1:0] keep_mask_full;
    logic [SYMBOLS-1:0]  keep_mask;
    logic [DATA_W-1:0]   masked_data;

    logic                fwd;
    logic                load_sop;
    logic                load_eop;
    logic [DATA_W-1:0]   load_data;
    logic [EMPTY_W-1:0]  load_empty;
    logic                start_msg;
    logic                normal_eop;
    logic                trunc;
    logic                miss_pulse;
    logic                unexp_pulse;

    assign untrusted_msg.rdy = out_rdy;
    assign accept            = untrusted_msg.valid && out_rdy;
    assign beat_inc          = beat_cnt_reg + ONE_BEAT;

    // Empty values that cannot describe a real beat are clamped to the largest legal one.
    always_comb begin
        empty_clamped = untrusted_msg.empty;
        if (int'(untrusted_msg.empty) >= SYMBOLS) begin
            empty_clamped = EMPTY_W'(SYMBOLS - 1);
        end
    end

    assign keep_mask_full = empty_to_mask(int'(empty_clamped));
    assign keep_mask      = keep_mask_full[SYMBOLS-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < SYMBOLS; gi++) begin : g_mask
            assign masked_data[8*gi +: 8] = keep_mask[gi] ? untrusted_msg.data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    // State and beat counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Framing decisions: what to forward, how to rewrite it, and the next state.
    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        fwd           = 1'b0;
        load_sop      = 1'b0;
        load_eop      = 1'b0;
        load_data     = untrusted_msg.data;
        load_empty    = '0;
        start_msg     = 1'b0;
        normal_eop    = 1'b0;
        trunc         = 1'b0;
        miss_pulse    = 1'b0;
        unexp_pulse   = 1'b0;

        if (accept) begin
            case (state_reg)
                IDLE: begin
                    if (untrusted_msg.sop) begin
                        start_msg = 1'b1;
                    end else begin
                        miss_pulse = 1'b1;
                    end
                end
                IN_MSG: begin
                    fwd           = 1'b1;
                    unexp_pulse   = untrusted_msg.sop;
                    beat_cnt_next = beat_inc;
                    if (untrusted_msg.eop) begin
                        normal_eop = 1'b1;
                        state_next = IDLE;
                    end else if (beat_inc == MAX_BEATS) begin
                        trunc      = 1'b1;
                        state_next = DROP;
                    end
                end
                DROP: begin
                    if (untrusted_msg.sop) begin
                        unexp_pulse = 1'b1;
                        start_msg   = 1'b1;
                    end else if (untrusted_msg.eop) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase

            // A SOP seen in IDLE or DROP opens a fresh message.
            if (start_msg) begin
                fwd           = 1'b1;
                load_sop      = 1'b1;
                beat_cnt_next = ONE_BEAT;
                if (untrusted_msg.eop) begin
                    normal_eop = 1'b1;
                    state_next = IDLE;
                end else if (MAX_MSG_BEATS == 1) begin
                    trunc      = 1'b1;
                    state_next = DROP;
                end else begin
                    state_next = IN_MSG;
                end
            end
        end

        if (normal_eop) begin
            load_eop   = 1'b1;
            load_empty = empty_clamped;
            load_data  = masked_data;
        end
        // Forced EOP keeps the full beat: empty stays 0 and data is unmasked.
        if (trunc) begin
            load_eop = 1'b1;
        end
    end

    avalon_st_out_reg #(
        .DATA_WIDTH_IN_BYTES (DATA_WIDTH_IN_BYTES)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (fwd),
        .in_sop   (load_sop),
        .in_eop   (load_eop),
        .in_data  (load_data),
        .in_empty (load_empty),
        .in_rdy   (out_rdy),
        .out      (enforced_msg)
    );

    // Indicators registered so they line up with the output register load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            missing_sop_indi    <= 1'b0;
            unexpected_sop_indi <= 1'b0;
            truncated_indi      <= 1'b0;
        end else begin
            missing_sop_indi    <= miss_pulse;
            unexpected_sop_indi <= unexp_pulse;
            truncated_indi      <= trunc;
        end
    end

`ifdef AVALON_ENFORCER_STATS_EN
    logic [2:0]           indi_vec;
    logic [CNT_WIDTH-1:0] stat_cnt_reg [3];

    assign indi_vec = {truncated_indi, unexpected_sop_indi, missing_sop_indi};

    generate
        for (gi = 0; gi < 3; gi++) begin : g_stats
            // Saturating event counter, cleared only by reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stat_cnt_reg[gi] <= '0;
                end else if (indi_vec[gi] && (stat_cnt_reg[gi] != {CNT_WIDTH{1'b1}})) begin
                    stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign missing_sop_cnt    = stat_cnt_reg[0];
    assign unexpected_sop_cnt = stat_cnt_reg[1];
    assign truncated_cnt      = stat_cnt_reg[2];
`endif

endmodule

// File: tb/tb_avalon_pkt_enforcer.sv
// Directed testbench for avalon_pkt_enforcer (16-byte beats, MAX_MSG_BEATS=4).
module tb_avalon_pkt_enforcer;
    import general_pack::*;

    localparam int NB  = 16;
    localparam int MAX = 4;
    localparam int CW  = 16;

    typedef logic [137:0] obs_t;

    logic clk;
    logic rst;
    logic miss;
    logic unexp;
    logic trunc;
`ifdef AVALON_ENFORCER_STATS_EN
    logic [CW-1:0] cnt_miss;
    logic [CW-1:0] cnt_unexp;
    logic [CW-1:0] cnt_trunc;
`endif

    int n_vec;
    int n_err;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) unt ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) enf ();

    avalon_pkt_enforcer #(
        .DATA_WIDTH_IN_BYTES (NB),
        .MAX_MSG_BEATS       (MAX),
        .CNT_WIDTH           (CW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .untrusted_msg       (unt.slave),
        .enforced_msg        (enf.master),
        .missing_sop_indi    (miss),
        .unexpected_sop_indi (unexp),
        .truncated_indi      (trunc)
`ifdef AVALON_ENFORCER_STATS_EN
        ,
        .missing_sop_cnt     (cnt_miss),
        .unexpected_sop_cnt  (cnt_unexp),
        .truncated_cnt       (cnt_trunc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t obs();
        return {enf.valid, enf.sop, enf.eop, enf.empty, enf.data, miss, unexp, trunc};
    endfunction

    function automatic obs_t mk(input logic v, input logic s, input logic e,
                                input logic [3:0] emp, input logic [127:0] d,
                                input logic m, input logic u, input logic t);
        return {v, s, e, emp, d, m, u, t};
    endfunction

    function automatic logic [3:0] ctl();
        return {enf.valid, miss, unexp, trunc};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [127:0] d, input logic [3:0] emp);
        unt.valid = v;
        unt.sop   = s;
        unt.eop   = e;
        unt.data  = d;
        unt.empty = emp;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, 4'd0);
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        enf.rdy = 1'b1;
        idle();
        cycle();
        cycle();
        n_vec++;
        if (obs() !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %h want 0", obs());
        end
        n_vec++;
        if (unt.rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rdy got %b want 1", unt.rdy);
        end
`ifdef AVALON_ENFORCER_STATS_EN
        n_vec++;
        if ({cnt_miss, cnt_unexp, cnt_trunc} !== '0) begin
            n_err++;
            $display("FAIL reset_cnt got %h want 0", {cnt_miss, cnt_unexp, cnt_trunc});
        end
`endif
        rst = 1'b1;
        cycle();
        $display("reset: outputs checked");
    endtask

    task automatic test_clean();
        obs_t e;
        drive(1'b1, 1'b1, 1'b0, {16{8'h11}}, 4'd0);
        cycle();
        e = mk(1'b1, 1'b1, 1'b0, 4'd0, {16{8'h11}}, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL clean_b1 got %h want %h", obs(), e); end
        $display("clean: beat 1 sop");
        drive(1'b1, 1'b0, 1'b0, {16{8'h22}}, 4'd3);
        cycle();
        e = mk(1'b1, 1'b0, 1'b0, 4'd0, {16{8'h22}}, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL clean_b2 got %h want %h", obs(), e); end
        $display("clean: beat 2 middle");
        drive(1'b1, 1'b0, 1'b1, {16{8'hC3}}, 4'd5);
        cycle();
        e = mk(1'b1, 1'b0, 1'b1, 4'd5, {{11{8'hC3}}, {5{8'h00}}}, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL clean_b3 got %h want %h", obs(), e); end
        $display("clean: beat 3 eop empty=5");
        idle();
        cycle();
        n_vec++;
        if (ctl() !== 4'b0000) begin n_err++; $display("FAIL clean_idle got %b want 0000", ctl()); end
        $display("clean: idle after message");
    endtask

    task automatic test_missing_sop();
        drive(1'b1, 1'b0, 1'b1, {16{8'h44}}, 4'd0);
        cycle();
        n_vec++;
        if (ctl() !== 4'b0100) begin n_err++; $display("FAIL missing_pulse got %b want 0100", ctl()); end
        $display("missing_sop: stray beat in IDLE");
        idle();
        cycle();
        n_vec++;
        if (ctl() !== 4'b0000) begin n_err++; $display("FAIL missing_clear got %b want 0000", ctl()); end
`ifdef AVALON_ENFORCER_STATS_EN
        n_vec++;
        if (cnt_miss !== 16'd1) begin n_err++; $display("FAIL missing_cnt got %0d want 1", cnt_miss); end
`endif
        $display("missing_sop: pulse ended");
    endtask

    task automatic test_unexpected_sop();
        obs_t e;
        drive(1'b1, 1'b1, 1'b0, {16{8'h55}}, 4'd0);
        cycle();
        e = mk(1'b1, 1'b1, 1'b0, 4'd0, {16{8'h55}}, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL unexp_b1 got %h want %h", obs(), e); end
        drive(1'b1, 1'b1, 1'b0, {16{8'h66}}, 4'd0);
        cycle();
        e = mk(1'b1, 1'b0, 1'b0, 4'd0, {16{8'h66}}, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL unexp_b2 got %h want %h", obs(), e); end
        $display("unexpected_sop: inner sop stripped");
        drive(1'b1, 1'b0, 1'b0, {16{8'h77}}, 4'd0);
        cycle();
        e = mk(1'b1, 1'b0, 1'b0, 4'd0, {16{8'h77}}, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL unexp_b3 got %h want %h", obs(), e); end
        drive(1'b1, 1'b0, 1'b1, {16{8'h88}}, 4'd0);
        cycle();
        e = mk(1'b1, 1'b0, 1'b1, 4'd0, {16{8'h88}}, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL unexp_b4 got %h want %h", obs(), e); end
        $display("unexpected_sop: message ended at eop");
        idle();
        cycle();
`ifdef AVALON_ENFORCER_STATS_EN
        n_vec++;
        if (cnt_unexp !== 16'd1) begin n_err++; $display("FAIL unexp_cnt got %0d want 1", cnt_unexp); end
`endif
    endtask

    task automatic test_truncation();
        obs_t e;
        logic [127:0] d;
        // Seven-beat message: beats 1-3 forwarded, beat 4 forced to EOP.
        for (int i = 1; i <= 3; i++) begin
            d = {16{8'(8'hA0 + i)}};
            drive(1'b1, (i == 1), 1'b0, d, 4'd0);
            cycle();
            e = mk(1'b1, (i == 1), 1'b0, 4'd0, d, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (obs() !== e) begin n_err++; $display("FAIL trunc_b%0d got %h want %h", i, obs(), e); end
        end
        drive(1'b1, 1'b0, 1'b0, {16{8'hA4}}, 4'd7);
        cycle();
        e = mk(1'b1, 1'b0, 1'b1, 4'd0, {16{8'hA4}}, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL trunc_b4 got %h want %h", obs(), e); end
        $display("truncation: beat 4 forced eop");
        for (int i = 5; i <= 7; i++) begin
            drive(1'b1, 1'b0, (i == 7), {16{8'hEE}}, 4'd0);
            cycle();
            n_vec++;
            if (ctl() !== 4'b0000) begin n_err++; $display("FAIL trunc_drop%0d got %b want 0000", i, ctl()); end
        end
        $display("truncation: beats 5-7 dropped");
        drive(1'b1, 1'b1, 1'b0, {16{8'hB1}}, 4'd0);
        cycle();
        e = mk(1'b1, 1'b1, 1'b0, 4'd0, {16{8'hB1}}, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL trunc_next1 got %h want %h", obs(), e); end
        drive(1'b1, 1'b0, 1'b1, {16{8'hB2}}, 4'd2);
        cycle();
        e = mk(1'b1, 1'b0, 1'b1, 4'd2, {{14{8'hB2}}, {2{8'h00}}}, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL trunc_next2 got %h want %h", obs(), e); end
        $display("truncation: following message intact");
        // Second truncation, then a sop+eop beat arriving in DROP.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, (i == 1), 1'b0, {16{8'hD0}}, 4'd0);
            cycle();
        end
        n_vec++;
        if (ctl() !== 4'b1001) begin n_err++; $display("FAIL trunc2_b4 got %b want 1001", ctl()); end
        drive(1'b1, 1'b1, 1'b1, {16{8'hC7}}, 4'd1);
        cycle();
        e = mk(1'b1, 1'b1, 1'b1, 4'd1, {{15{8'hC7}}, 8'h00}, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL drop_sop got %h want %h", obs(), e); end
        $display("truncation: sop+eop in DROP forwarded");
        drive(1'b1, 1'b0, 1'b0, {16{8'h99}}, 4'd0);
        cycle();
        n_vec++;
        if (ctl() !== 4'b0100) begin n_err++; $display("FAIL drop_to_idle got %b want 0100", ctl()); end
        idle();
        cycle();
`ifdef AVALON_ENFORCER_STATS_EN
        n_vec++;
        if ({cnt_miss, cnt_unexp, cnt_trunc} !== {16'd2, 16'd2, 16'd2}) begin
            n_err++;
            $display("FAIL trunc_cnts got %h want %h", {cnt_miss, cnt_unexp, cnt_trunc}, {16'd2, 16'd2, 16'd2});
        end
`endif
    endtask

    task automatic test_backpressure();
        obs_t e;
        drive(1'b1, 1'b1, 1'b0, {16{8'h01}}, 4'd0);
        cycle();
        e = mk(1'b1, 1'b1, 1'b0, 4'd0, {16{8'h01}}, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL bp_p1 got %h want %h", obs(), e); end
        drive(1'b1, 1'b0, 1'b0, {16{8'h02}}, 4'd0);
        enf.rdy = 1'b0;
        #1;
        n_vec++;
        if (unt.rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy_low got %b want 0", unt.rdy); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++;
            if (obs() !== e || unt.rdy !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d got %h rdy %b want %h rdy 0", i, obs(), unt.rdy, e);
            end
        end
        $display("backpressure: held 3 cycles");
        enf.rdy = 1'b1;
        #1;
        n_vec++;
        if (unt.rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_high got %b want 1", unt.rdy); end
        cycle();
        e = mk(1'b1, 1'b0, 1'b0, 4'd0, {16{8'h02}}, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL bp_p2 got %h want %h", obs(), e); end
        drive(1'b1, 1'b0, 1'b1, {16{8'h03}}, 4'd0);
        cycle();
        e = mk(1'b1, 1'b0, 1'b1, 4'd0, {16{8'h03}}, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL bp_p3 got %h want %h", obs(), e); end
        idle();
        cycle();
        n_vec++;
        if (ctl() !== 4'b0000) begin n_err++; $display("FAIL bp_idle got %b want 0000", ctl()); end
        $display("backpressure: order preserved");
    endtask

    task automatic test_reset_mid();
        obs_t e;
        drive(1'b1, 1'b1, 1'b0, {16{8'h5A}}, 4'd0);
        cycle();
        e = mk(1'b1, 1'b1, 1'b0, 4'd0, {16{8'h5A}}, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL rstmid_b1 got %h want %h", obs(), e); end
        drive(1'b1, 1'b0, 1'b0, {16{8'h5B}}, 4'd0);
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (obs() !== '0) begin n_err++; $display("FAIL rstmid_clear got %h want 0", obs()); end
        cycle();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, {16{8'h5C}}, 4'd0);
        cycle();
        n_vec++;
        if (ctl() !== 4'b0100) begin n_err++; $display("FAIL rstmid_nosop got %b want 0100", ctl()); end
        idle();
        cycle();
`ifdef AVALON_ENFORCER_STATS_EN
        n_vec++;
        if (cnt_miss !== 16'd1) begin n_err++; $display("FAIL rstmid_cnt got %0d want 1", cnt_miss); end
`endif
        $display("reset_mid: beat without sop dropped");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_clean();
        test_missing_sop();
        test_unexpected_sop();
        test_truncation();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
